// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game controller: one-hot state encoding,
// coordinate width and screen geometry.
package flappy_pkg;

  localparam int COORD_W       = 10;
  localparam int SCREEN_W      = 640;
  localparam int SCREEN_BOTTOM = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_START = 6'b000010,
    S_RUN   = 6'b000100,
    S_STOP  = 6'b001000,
    S_OVER  = 6'b010000,
    S_ACK   = 6'b100000
  } state_e;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Bundle between the game controller (master) and the physics/pipe datapath
// (slave). HiScore exists only when FLAPPY_HISCORE_EN is defined.
interface flappy_game_ctrl_if #(
  parameter int SCORE_W = 8
);

  flappy_pkg::coord_t Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
  flappy_pkg::coord_t Pipe_X_L, Pipe_X_R;
  flappy_pkg::coord_t Gap_Y_T, Gap_Y_B;

  // Physics handshake: each request (Start/Stop/Ack) is raised by the master
  // and held steady until the slave shows the matching one-hot state
  // (Flight/Stop/Initial); the request drops on the edge that sees it.
  logic Phys_q_Initial, Phys_q_Flight, Phys_q_Stop;
  logic Phys_Start, Phys_Stop, Phys_Ack;

  logic               Tick;
  logic               Flap;
  logic [SCORE_W-1:0] Score;
  logic q_Idle, q_Start, q_Run, q_Stop, q_Over, q_Ack;
`ifdef FLAPPY_HISCORE_EN
  logic [SCORE_W-1:0] HiScore;
`endif

  modport master (
    input  Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B,
    input  Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B,
    input  Phys_q_Initial, Phys_q_Flight, Phys_q_Stop,
    output Phys_Start, Phys_Stop, Phys_Ack,
    output Tick, Flap, Score,
    output q_Idle, q_Start, q_Run, q_Stop, q_Over, q_Ack
`ifdef FLAPPY_HISCORE_EN
    , output HiScore
`endif
  );

  modport slave (
    output Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B,
    output Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B,
    output Phys_q_Initial, Phys_q_Flight, Phys_q_Stop,
    input  Phys_Start, Phys_Stop, Phys_Ack,
    input  Tick, Flap, Score,
    input  q_Idle, q_Start, q_Run, q_Stop, q_Over, q_Ack
`ifdef FLAPPY_HISCORE_EN
    , input HiScore
`endif
  );

endinterface

// File: rtl/flappy_game_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for the raw flap button followed by a rising-edge
// detector; pulse_o is high for one Clk cycle per press.
module btn_sync_edge (
  input  logic Clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: frame tick, flap latching, collision, scoring and physics
// handshakes. Define FLAPPY_HISCORE_EN to add the persistent HiScore output.
module flappy_game_ctrl #(
  parameter int TICK_DIV      = 416667,
  parameter int SCREEN_BOTTOM = flappy_pkg::SCREEN_BOTTOM,
  parameter int SCORE_W       = 8
) (
  input logic                Clk,
  input logic                reset,
  input logic                BtnRaw,
  flappy_game_ctrl_if.master bus
);

  import flappy_pkg::*;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q;
  logic               pend_q, passed_q, coll_q, coll_d;
  logic               btn_pulse, tick_w, pipe_behind;
  logic               x_ovl, y_out;
`ifdef FLAPPY_HISCORE_EN
  logic [SCORE_W-1:0] hi_q;
`endif

  btn_sync_edge u_btn (
    .Clk     (Clk),
    .reset   (reset),
    .btn_i   (BtnRaw),
    .pulse_o (btn_pulse)
  );

  // Free-running frame divider, independent of game state.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_w = (cnt_q == CNT_LAST);

  always_comb begin
    x_ovl  = (bus.Bird_X_R >= bus.Pipe_X_L) && (bus.Bird_X_L <= bus.Pipe_X_R);
    y_out  = (bus.Bird_Y_T < bus.Gap_Y_T) || (bus.Bird_Y_B > bus.Gap_Y_B);
    coll_d = (bus.Bird_Y_B >= COORD_W'(SCREEN_BOTTOM)) || (x_ovl && y_out);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end

  assign pipe_behind = (bus.Pipe_X_R < bus.Bird_X_L);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      pend_q   <= 1'b0;
      passed_q <= 1'b0;
`ifdef FLAPPY_HISCORE_EN
      hi_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (btn_pulse) begin
            state_q  <= S_START;
            score_q  <= '0;
            passed_q <= 1'b0;
          end
        end
        S_START: begin
          if (bus.Phys_q_Flight) state_q <= S_RUN;
        end
        S_RUN: begin
          if (tick_w) begin
            // The tick consumes the latched press; a press on this very cycle
            // is folded into the Flap output instead of being latched.
            pend_q <= 1'b0;
            if (pipe_behind) begin
              if (!passed_q) begin
                passed_q <= 1'b1;
                if (score_q != '1) score_q <= score_q + 1'b1;
              end
            end else begin
              passed_q <= 1'b0;
            end
            if (coll_q) state_q <= S_STOP;
          end else if (btn_pulse) begin
            pend_q <= 1'b1;
          end
        end
        S_STOP: begin
          if (bus.Phys_q_Stop) begin
            state_q <= S_OVER;
`ifdef FLAPPY_HISCORE_EN
            if (score_q > hi_q) hi_q <= score_q;
`endif
          end
        end
        S_OVER: begin
          if (btn_pulse) state_q <= S_ACK;
        end
        S_ACK: begin
          if (bus.Phys_q_Initial) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Phys_Start = (state_q == S_START);
  assign bus.Phys_Stop  = (state_q == S_STOP);
  assign bus.Phys_Ack   = (state_q == S_ACK);
  assign bus.Tick       = tick_w;
  assign bus.Flap       = (state_q == S_RUN) && tick_w && (pend_q || btn_pulse);
  assign bus.Score      = score_q;
  assign bus.q_Idle     = (state_q == S_IDLE);
  assign bus.q_Start    = (state_q == S_START);
  assign bus.q_Run      = (state_q == S_RUN);
  assign bus.q_Stop     = (state_q == S_STOP);
  assign bus.q_Over     = (state_q == S_OVER);
  assign bus.q_Ack      = (state_q == S_ACK);
`ifdef FLAPPY_HISCORE_EN
  assign bus.HiScore    = hi_q;
`endif

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with a small physics responder model;
// expected values are queued at stimulus time and popped at each check.
module tb_flappy_game_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SW       = 8;

  localparam logic [5:0] ST_IDLE  = 6'b000001;
  localparam logic [5:0] ST_START = 6'b000010;
  localparam logic [5:0] ST_RUN   = 6'b000100;
  localparam logic [5:0] ST_STOP  = 6'b001000;
  localparam logic [5:0] ST_OVER  = 6'b010000;
  localparam logic [5:0] ST_ACK   = 6'b100000;

  logic Clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic BtnRaw = 1'b0;
  logic phys_stall = 1'b0;
  logic p_init, p_flight, p_stop;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  flappy_game_ctrl_if #(.SCORE_W(SW)) bus ();

  flappy_game_ctrl #(
    .TICK_DIV      (TICK_DIV),
    .SCREEN_BOTTOM (480),
    .SCORE_W       (SW)
  ) dut (
    .Clk    (Clk),
    .reset  (rst_n),
    .BtnRaw (BtnRaw),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  // Physics responder: answers each request one clock after seeing it.
  always @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      p_init   <= 1'b1;
      p_flight <= 1'b0;
      p_stop   <= 1'b0;
    end else if (!phys_stall) begin
      if (bus.Phys_Start && p_init) begin
        p_init   <= 1'b0;
        p_flight <= 1'b1;
      end else if (bus.Phys_Stop && p_flight) begin
        p_flight <= 1'b0;
        p_stop   <= 1'b1;
      end else if (bus.Phys_Ack && p_stop) begin
        p_stop <= 1'b0;
        p_init <= 1'b1;
      end
    end
  end

  assign bus.Phys_q_Initial = p_init;
  assign bus.Phys_q_Flight  = p_flight;
  assign bus.Phys_q_Stop    = p_stop;

  function automatic logic [5:0] qvec();
    return {bus.q_Ack, bus.q_Over, bus.q_Stop, bus.q_Run, bus.q_Start, bus.q_Idle};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic wait_state(input string tag, input logic [5:0] st, input int budget);
    expect_val(32'(st));
    for (int i = 0; i < budget && qvec() !== st; i++) step(1);
    check(tag, 32'(qvec()));
  endtask

  task automatic to_tick();
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < TICK_DIV * 4 && !hit; i++) begin
      step(1);
      hit = bus.Tick;
    end
    if (!hit) begin
      expect_val(32'd1);
      check("tick_wait", 32'(bus.Tick));
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      to_tick();
      step(1);
    end
  endtask

  task automatic press();
    BtnRaw = 1'b1;
    step(1);
    BtnRaw = 1'b0;
  endtask

  task automatic set_bird(input int xl, input int xr, input int yt, input int yb);
    bus.Bird_X_L = 10'(xl);
    bus.Bird_X_R = 10'(xr);
    bus.Bird_Y_T = 10'(yt);
    bus.Bird_Y_B = 10'(yb);
  endtask

  task automatic set_pipe(input int xl, input int xr);
    bus.Pipe_X_L = 10'(xl);
    bus.Pipe_X_R = 10'(xr);
  endtask

  task automatic set_gap(input int yt, input int yb);
    bus.Gap_Y_T = 10'(yt);
    bus.Gap_Y_B = 10'(yb);
  endtask

  task automatic count_flaps(input int n, output int flaps, output int bad, output int first);
    int ticks;
    ticks = 0; flaps = 0; bad = 0; first = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (bus.Tick) ticks++;
      if (bus.Flap) begin
        flaps++;
        if (!bus.Tick) bad++;
        if (first == 0) first = ticks;
      end
    end
  endtask

  task automatic wait_state_and_count_stop(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (bus.Phys_Stop) cnt++;
    end
  endtask

  initial begin
    int start_cnt, flaps, bad, first, stop_cnt;

    // Reset state
    set_bird(100, 120, 200, 220);
    set_pipe(400, 450);
    set_gap(150, 300);
    rst_n = 1'b0;
    step(2);
    expect_val(32'(ST_IDLE)); check("rst_state", 32'(qvec()));
    expect_val(32'd0);
    check("rst_outputs", 32'({bus.Phys_Start, bus.Phys_Stop, bus.Phys_Ack, bus.Tick, bus.Flap}));
    expect_val(32'd0); check("rst_score", 32'(bus.Score));
`ifdef FLAPPY_HISCORE_EN
    expect_val(32'd0); check("rst_hiscore", 32'(bus.HiScore));
`endif
    rst_n = 1'b1;
    step(3);

    // Game A: start handshake
    press();
    start_cnt = 0;
    for (int i = 0; i < 20 && !bus.q_Run; i++) begin
      step(1);
      if (bus.Phys_Start) start_cnt++;
    end
    expect_val(32'd2); check("start_cycles", 32'(start_cnt));
    wait_state("run_entry", ST_RUN, 5);
    expect_val(32'd0); check("start_drop", 32'(bus.Phys_Start));
    expect_val(32'd0); check("score_start", 32'(bus.Score));

    // Press one cycle after a tick: flap on the next tick only
    to_tick();
    step(1);
    BtnRaw = 1'b1;
    step(1);
    BtnRaw = 1'b0;
    count_flaps(10, flaps, bad, first);
    expect_val(32'd1); check("flap_single_count", 32'(flaps));
    expect_val(32'd0); check("flap_off_tick", 32'(bad));
    expect_val(32'd1); check("flap_next_tick", 32'(first));

    // Two presses inside one tick window: a single flap
    to_tick();
    BtnRaw = 1'b1; step(1);
    BtnRaw = 1'b0; step(1);
    BtnRaw = 1'b1; step(1);
    BtnRaw = 1'b0;
    count_flaps(10, flaps, bad, first);
    expect_val(32'd1); check("flap_double_count", 32'(flaps));
    expect_val(32'd0); check("flap_double_off_tick", 32'(bad));

    // Scoring: one increment per pass, re-armed by pipe recycling
    set_bird(230, 250, 200, 220);
    set_pipe(255, 260);
    tick_n(2);
    set_pipe(215, 220);
    tick_n(3);
    expect_val(32'd1); check("score_first_pass", 32'(bus.Score));
    set_pipe(595, 600); tick_n(1);
    set_pipe(215, 220); tick_n(2);
    expect_val(32'd2); check("score_second_pass", 32'(bus.Score));
    set_pipe(595, 600); tick_n(1);
    set_pipe(215, 220); tick_n(1);
    expect_val(32'd3); check("score_third_pass", 32'(bus.Score));

    // Inside the gap with X overlap: no collision; then above the gap
    set_pipe(240, 280);
    set_gap(200, 260);
    set_bird(230, 250, 220, 240);
    tick_n(2);
    expect_val(32'(ST_RUN)); check("gap_clear_state", 32'(qvec()));
    expect_val(32'd3); check("gap_clear_score", 32'(bus.Score));
    set_bird(230, 250, 190, 210);
    tick_n(1);
    expect_val(32'(ST_STOP)); check("gap_hit_state", 32'(qvec()));
    wait_state("gap_over", ST_OVER, 10);
    expect_val(32'd3); check("over_score_a", 32'(bus.Score));
`ifdef FLAPPY_HISCORE_EN
    expect_val(32'd3); check("hiscore_a", 32'(bus.HiScore));
`endif
    press();
    wait_state("ack_a", ST_ACK, 10);
    expect_val(32'd1); check("ack_req_a", 32'(bus.Phys_Ack));
    wait_state("idle_a", ST_IDLE, 10);
    expect_val(32'd3); check("idle_score_held", 32'(bus.Score));

    // Game B: score clears on start; ground collision with slow physics
    set_bird(100, 120, 200, 220);
    set_pipe(400, 450);
    set_gap(150, 300);
    press();
    wait_state("run_b", ST_RUN, 20);
    expect_val(32'd0); check("score_cleared_b", 32'(bus.Score));
    set_bird(230, 250, 200, 220);
    set_pipe(255, 260); tick_n(1);
    set_pipe(215, 220); tick_n(1);
    expect_val(32'd1); check("score_b", 32'(bus.Score));
    set_bird(230, 250, 460, 480);
    phys_stall = 1'b1;
    tick_n(1);
    expect_val(32'(ST_STOP)); check("ground_stop", 32'(qvec()));
    wait_state_and_count_stop(5, stop_cnt);
    expect_val(32'd5); check("stop_held", 32'(stop_cnt));
    phys_stall = 1'b0;
    wait_state("over_b", ST_OVER, 10);
    expect_val(32'd1); check("over_score_b", 32'(bus.Score));
`ifdef FLAPPY_HISCORE_EN
    expect_val(32'd3); check("hiscore_b", 32'(bus.HiScore));
`endif
    press();
    wait_state("ack_b", ST_ACK, 10);
    wait_state("idle_b", ST_IDLE, 10);

    // Game C: saturate the score, then reset while in STOP
    set_bird(100, 120, 200, 220);
    set_pipe(400, 450);
    press();
    wait_state("run_c", ST_RUN, 20);
    set_bird(230, 250, 200, 220);
    for (int i = 0; i < 256; i++) begin
      set_pipe(595, 600); tick_n(1);
      set_pipe(215, 220); tick_n(1);
    end
    expect_val(32'd255); check("score_saturate", 32'(bus.Score));
    set_bird(230, 250, 460, 480);
    phys_stall = 1'b1;
    tick_n(1);
    expect_val(32'(ST_STOP)); check("stop_c", 32'(qvec()));
    #2;
    rst_n = 1'b0;
    #1;
    expect_val(32'(ST_IDLE)); check("async_rst_state", 32'(qvec()));
    expect_val(32'd0);
    check("async_rst_outputs", 32'({bus.Phys_Start, bus.Phys_Stop, bus.Phys_Ack, bus.Tick, bus.Flap}));
    expect_val(32'd0); check("async_rst_score", 32'(bus.Score));
`ifdef FLAPPY_HISCORE_EN
    expect_val(32'd0); check("async_rst_hiscore", 32'(bus.HiScore));
`endif
    step(2);
    phys_stall = 1'b0;
    rst_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
